fir_macc_seq: RTL



---
 rtl/fir_macc_seq_pkg.sv | 22 ++
 rtl/fir_sample_ring.sv | 40 ++++
 rtl/fir_macc_seq.sv | 106 ++++++++++
 3 files changed

// File: rtl/fir_macc_seq_pkg.sv
// rtl/fir_macc_seq_pkg.sv - shared constants, FSM state type and width helper for fir_macc_seq
package fir_macc_seq_pkg;

  localparam int MACC_LAT_DEF = 3;

  // bit positions inside macc_ce = {c,b,a}
  localparam int CE_A = 0;
  localparam int CE_B = 1;
  localparam int CE_C = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    OUT
  } fir_state_t;

  function automatic int out_w(input int s);
    return 48 - s;
  endfunction

endpackage

// File: rtl/fir_sample_ring.sv
// rtl/fir_sample_ring.sv - circular sample history with saturating fill and zero-if-unfilled registered read
module fir_sample_ring #(
  parameter int N_TAPS = 16,
  parameter int CW     = $clog2(N_TAPS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [24:0]   wr_data,
  input  logic [CW-1:0] rd_off,
  output logic [24:0]   rd_data
);

  logic [24:0]   mem [N_TAPS];
  logic [CW-1:0] wptr;
  logic [CW:0]   fill;
  logic [CW-1:0] rd_idx;

  // newest sample sits one slot behind wptr; offsets count back in time
  assign rd_idx = wptr - CW'(1) - rd_off;

  always_ff @(posedge clock) begin
    if (wr_en) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr    <= '0;
      fill    <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + CW'(1);
        if (fill != (CW+1)'(N_TAPS)) fill <= fill + (CW+1)'(1);
      end
      rd_data <= ({1'b0, rd_off} < fill) ? mem[rd_idx] : '0;
    end
  end

endmodule

// File: rtl/fir_macc_seq.sv
// rtl/fir_macc_seq.sv - time-multiplexed FIR controller driving an external single-DSP macc
module fir_macc_seq
  import fir_macc_seq_pkg::*;
#(
  parameter int          N_TAPS   = 16,
  parameter int          CW       = $clog2(N_TAPS),
  parameter int          S        = 0,
  parameter int          MACC_LAT = MACC_LAT_DEF,
  parameter int          R_LAG    = 1,
  parameter logic [47:0] ROUND    = 48'd0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [24:0]         in_data,
  output logic [CW-1:0]       coef_addr,
  input  logic [17:0]         coef_data,
  output logic [24:0]         macc_a,
  output logic [17:0]         macc_b,
  output logic [47:0]         macc_c,
  output logic [2:0]          macc_ce,
  output logic                macc_r,
  input  logic [out_w(S)-1:0] macc_p,
  output logic                out_valid,
  output logic [out_w(S)-1:0] out_data
);

  localparam logic [15:0] ISSUE_END = 16'(N_TAPS);
  localparam logic [15:0] CAP_STEP  = 16'(N_TAPS + MACC_LAT + 1);
  localparam logic [15:0] R_STEP    = 16'(R_LAG + 1);
  localparam logic [2:0]  CE_ALL    = 3'((1 << CE_A) | (1 << CE_B) | (1 << CE_C));

  fir_state_t  state;
  logic [15:0] step;
  logic        tap_v;
  logic        accept;
  logic [24:0] ring_data;

  // OUT hands back to IDLE in the same cycle, so it already accepts
  assign in_ready = ~reset & ((state == IDLE) | (state == OUT));
  assign accept   = in_valid & in_ready;
  assign macc_c   = ROUND;
  assign macc_ce  = CE_ALL;
  assign macc_a   = tap_v ? ring_data : '0;
  assign macc_b   = tap_v ? coef_data : '0;

  fir_sample_ring #(
    .N_TAPS(N_TAPS),
    .CW    (CW)
  ) u_ring (
    .clock  (clock),
    .reset  (reset),
    .wr_en  (accept),
    .wr_data(in_data),
    .rd_off (coef_addr),
    .rd_data(ring_data)
  );

  // step counts cycles since the accept cycle; every later event is keyed off it
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      step      <= '0;
      coef_addr <= '0;
      tap_v     <= 1'b0;
      macc_r    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      tap_v     <= (state == ISSUE);
      macc_r    <= (state == ISSUE) && (step == R_STEP);
      coef_addr <= (state == ISSUE) ? coef_addr + CW'(1) : '0;
      out_valid <= 1'b0;
      step      <= step + 16'd1;
      case (state)
        IDLE: begin
          if (accept) begin
            state <= ISSUE;
            step  <= 16'd1;
          end
        end
        ISSUE: begin
          if (step == ISSUE_END) state <= DRAIN;
        end
        DRAIN: begin
          if (step == CAP_STEP) begin
            state     <= OUT;
            out_valid <= 1'b1;
            out_data  <= macc_p;
          end
        end
        OUT: begin
          if (accept) begin
            state <= ISSUE;
            step  <= 16'd1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
